rv_div_requester: RTL
=====================

# rv_div_requester

Initiator-side controller for the team's iterative unsigned divider. It accepts RV32M-style DIV/DIVU/REM/REMU requests from the execute stage and handles RISC-V special cases (divide-by-zero, signed overflow) without invoking the divider. Signed operands are converted to magnitudes before the unsigned divider's start/ready/valid/error handshake runs, and signs are restored on the returned quotient or remainder. It sits between the ALU dispatch logic and the unsigned divider instance.

## Interface
- SIZE, 32, operand/result width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE
- req_op  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
- req_a  in  SIZE  dividend
- req_b  in  SIZE  divisor
- flush  in  1  abandon in-flight request, no result produced
- result_valid  out  1  one-cycle pulse, result is valid
- result  out  SIZE  quotient or remainder per op; held until next result
- div_start  out  1  start to divider
- div_ready  in  1  divider idle
- div_valid  in  1  divider done, one-cycle pulse
- div_error  in  1  divider saw zero divisor
- div_dividend  out  SIZE  unsigned dividend magnitude
- div_divisor  out  SIZE  unsigned divisor magnitude
- div_quotient  in  SIZE  unsigned quotient
- div_remainder  in  SIZE  unsigned remainder

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN, DONE.
- Accept on req_valid && req_ready. Register op, a, b, sign_a = a[SIZE-1] && signed op, sign_b likewise.
- Bypass on accept, going straight to DONE:
  - b == 0: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed op with a == 1<<(SIZE-1) and b == all-ones: DIV gives a; REM gives 0.
- Otherwise go to ISSUE. div_dividend = sign_a ? -a : a, and div_divisor = sign_b ? -b : b. Both are driven from registers and stay stable through ISSUE and WAIT.
- ISSUE: div_start=1. On div_start && div_ready, go to WAIT. While div_ready=0, stay in ISSUE. This covers a divider that is not idle after reset, since the divider has no reset.
- WAIT: on div_valid, compute the result:
  - DIV: sign_a^sign_b ? -q : q
  - DIVU: q
  - REM: sign_a ? -r : r
  - REMU: r
  - Then go to DONE.
- div_valid && div_error in WAIT cannot occur in normal operation. If it does, apply the divide-by-zero result above.
- DONE: result_valid=1 for one cycle, then IDLE.
- flush:
  - ISSUE, start not yet taken (div_ready=0 that cycle): go to IDLE. Flush wins over start in the same cycle, so div_start is gated off.
  - ISSUE with div_ready=1, or WAIT: go to DRAIN.
  - DRAIN: div_start=0, req_ready=0. On div_valid go to IDLE, result discarded.
  - DONE: result_valid still pulses. flush has no effect in IDLE.
- Only div_valid in WAIT or DRAIN is consumed. A stale div_valid seen in IDLE or ISSUE is ignored.
- All negation is two's complement modulo 2^SIZE.

## Timing
- Reset values: state=IDLE, req_ready=1, result_valid=0, result=0, div_start=0, div_dividend=0, div_divisor=0.
- Reset mid-operation returns to IDLE immediately. The next request waits in ISSUE until div_ready.
- Accept at edge T:
  - Bypass: result_valid in cycle T+1.
  - Normal with |b| > |a|: divider finishes immediately, result_valid in cycle T+3.
  - Normal otherwise: result_valid in cycle T+3+SIZE (T+35 for SIZE=32).
- Stalls on div_ready=0 add cycles one-for-one.
- req_ready is low from T+1 through the DONE cycle. The next request can be accepted the cycle after DONE.
- No backpressure on result. A consumer must sample it on the result_valid cycle, or use the held value.

## Test plan
- DIV a=-7 (0xFFFFFFF9), b=2 -> result 0xFFFFFFFD (-3) at T+35. REM, same operands -> 0xFFFFFFFF (-1).
- DIVU a=100, b=7 -> 14 at T+35. REMU -> 2. DIVU a=3, b=10 -> 0 at T+3.
- DIV a=5, b=0 -> 0xFFFFFFFF at T+1, div_start never asserted. REMU a=5, b=0 -> 5.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at T+1. REM, same operands -> 0.
- Flush during WAIT, cycle T+10:
  - req_ready stays low until div_valid, and no result_valid is produced.
  - A following DIVU 9/3 then returns 3 correctly.
- Reset pulse in WAIT while the divider is busy:
  - Outputs return to reset values immediately.
  - A new request holds div_start until div_ready, and the stale div_valid does not produce result_valid.
  - The correct result follows.

Source files
------------

// File: rtl/rv_div_requester.sv
// Initiator-side controller for the iterative unsigned divider: RV32M DIV/DIVU/REM/REMU with
// divide-by-zero and signed-overflow bypass, sign stripping before the divider and restoration after.
module rv_div_requester #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [SIZE-1:0] req_a,
  input  logic [SIZE-1:0] req_b,
  input  logic            flush,
  output logic            result_valid,
  output logic [SIZE-1:0] result,
  output logic            div_start,
  input  logic            div_ready,
  input  logic            div_valid,
  input  logic            div_error,
  output logic [SIZE-1:0] div_dividend,
  output logic [SIZE-1:0] div_divisor,
  input  logic [SIZE-1:0] div_quotient,
  input  logic [SIZE-1:0] div_remainder,
  output logic [2:0]      dbg_state
);

  // Handshakes: a request transfers on req_valid && req_ready; the divider takes a job on
  // div_start && div_ready; div_valid is a one-cycle completion pulse that is only consumed in WAIT/DRAIN.
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE} state_t;

  localparam logic [SIZE-1:0] ALL_ONES = '1;
  localparam logic [SIZE-1:0] MIN_NEG  = {1'b1, {(SIZE-1){1'b0}}};

  state_t          state;
  logic [1:0]      op;
  logic            sign_a;
  logic            sign_b;
  logic [SIZE-1:0] a_q;

  logic            req_signed;
  logic            in_sign_a;
  logic            in_sign_b;
  logic            bypass;
  logic [SIZE-1:0] bypass_res;
  logic [SIZE-1:0] wait_res;

  assign req_signed = ~req_op[0];
  assign in_sign_a  = req_signed & req_a[SIZE-1];
  assign in_sign_b  = req_signed & req_b[SIZE-1];
  assign dbg_state  = state;

  // A flush in ISSUE while the divider is busy withdraws the start in the same cycle.
  assign div_start = (state == S_ISSUE) && !(flush && !div_ready);

  always_comb begin
    bypass     = 1'b0;
    bypass_res = '0;
    if (req_b == '0) begin
      bypass     = 1'b1;
      bypass_res = req_op[1] ? req_a : ALL_ONES;
    end else if (req_signed && (req_a == MIN_NEG) && (req_b == ALL_ONES)) begin
      bypass     = 1'b1;
      bypass_res = req_op[1] ? '0 : req_a;
    end
  end

  always_comb begin
    wait_res = '0;
    case (op)
      2'd0:    wait_res = (sign_a ^ sign_b) ? -div_quotient : div_quotient;
      2'd1:    wait_res = div_quotient;
      2'd2:    wait_res = sign_a ? -div_remainder : div_remainder;
      default: wait_res = div_remainder;
    endcase
    if (div_error) begin
      wait_res = op[1] ? a_q : ALL_ONES;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      req_ready    <= 1'b1;
      result_valid <= 1'b0;
      result       <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      op           <= 2'd0;
      sign_a       <= 1'b0;
      sign_b       <= 1'b0;
      a_q          <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op           <= req_op;
            a_q          <= req_a;
            sign_a       <= in_sign_a;
            sign_b       <= in_sign_b;
            div_dividend <= in_sign_a ? -req_a : req_a;
            div_divisor  <= in_sign_b ? -req_b : req_b;
            req_ready    <= 1'b0;
            if (bypass) begin
              result       <= bypass_res;
              result_valid <= 1'b1;
              state        <= S_DONE;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (flush && !div_ready) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
          end else if (flush) begin
            state <= S_DRAIN;
          end else if (div_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (div_valid) begin
            if (flush) begin
              state     <= S_IDLE;
              req_ready <= 1'b1;
            end else begin
              result       <= wait_res;
              result_valid <= 1'b1;
              state        <= S_DONE;
            end
          end else if (flush) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (div_valid) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
